// File: rtl/amo_rmw_engine.sv
// amo_rmw_engine: runs one committed atomic (LR/SC/AMO) as a read-modify-write on a
// single-ported memory port and owns the hart's LR/SC reservation. Optional: AMO_RSV_TIMEOUT_EN.
module amo_rmw_engine #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned RSV_TIMEOUT = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              amo_req_valid_i,
  input  logic [3:0]        amo_op_i,
  input  logic [1:0]        amo_size_i,
  input  logic [ADDR_W-1:0] amo_addr_i,
  input  logic [DATA_W-1:0] amo_operand_i,
  output logic              amo_ack_o,
  output logic [DATA_W-1:0] amo_result_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [7:0]        mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              snoop_inval_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              busy_o
);

  localparam logic [3:0] OP_NONE = 4'd0,  OP_LR   = 4'd1,  OP_SC  = 4'd2,  OP_SWAP = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4,  OP_AND  = 4'd5,  OP_OR  = 4'd6,  OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MAX  = 4'd8,  OP_MAXU = 4'd9,  OP_MIN = 4'd10, OP_MINU = 4'd11;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_e;

  state_e              state_q;
  logic [3:0]          op_q;
  logic                is_word_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   operand_q;
  logic                rsv_valid_q;
  logic [ADDR_W-4:0]   rsv_addr_q;
  logic                rsv_timeout;

  logic                req_word, req_legal, rsv_live, sc_match, sc_take;
  logic                lr_done, wr_done, snoop_hit_rsv, snoop_hit_cur;
  logic [7:0]          req_be, q_be;
  logic [31:0]         old_w, opnd_w, new_w;
  logic [DATA_W-1:0]   new_dw, new_wdata, old_ext;
  logic                unused_ok;

  assign busy_o    = (state_q != IDLE);
  assign unused_ok = ^{addr_q[1:0], snoop_addr_i[2:0], RSV_TIMEOUT};

  always_comb begin
    req_word      = (amo_size_i == 2'b10);
    req_legal     = (amo_op_i != OP_NONE) && (amo_op_i <= OP_MINU) && amo_size_i[1];
    req_be        = req_word ? (amo_addr_i[2] ? 8'hF0 : 8'h0F) : 8'hFF;
    q_be          = is_word_q ? (addr_q[2] ? 8'hF0 : 8'h0F) : 8'hFF;
    // A timeout expiring this cycle already counts as a lost reservation.
    rsv_live      = rsv_valid_q && !rsv_timeout;
    sc_match      = rsv_live && (rsv_addr_q == amo_addr_i[ADDR_W-1:3]);
    sc_take       = (state_q == IDLE) && amo_req_valid_i && req_legal && (amo_op_i == OP_SC);
    lr_done       = (state_q == RD_WAIT) && mem_rvalid_i && (op_q == OP_LR);
    wr_done       = (state_q == WR_REQ) && mem_gnt_i;
    snoop_hit_rsv = snoop_inval_i && (snoop_addr_i[ADDR_W-1:3] == rsv_addr_q);
    snoop_hit_cur = snoop_inval_i && (snoop_addr_i[ADDR_W-1:3] == addr_q[ADDR_W-1:3]);
  end

  always_comb begin
    old_w   = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    opnd_w  = operand_q[31:0];
    old_ext = is_word_q ? {{32{old_w[31]}}, old_w} : mem_rdata_i;
    new_w   = opnd_w;
    new_dw  = operand_q;
    case (op_q)
      OP_ADD:  begin new_w = old_w + opnd_w; new_dw = mem_rdata_i + operand_q; end
      OP_AND:  begin new_w = old_w & opnd_w; new_dw = mem_rdata_i & operand_q; end
      OP_OR:   begin new_w = old_w | opnd_w; new_dw = mem_rdata_i | operand_q; end
      OP_XOR:  begin new_w = old_w ^ opnd_w; new_dw = mem_rdata_i ^ operand_q; end
      OP_MAX:  begin
        new_w  = ($signed(old_w) > $signed(opnd_w)) ? old_w : opnd_w;
        new_dw = ($signed(mem_rdata_i) > $signed(operand_q)) ? mem_rdata_i : operand_q;
      end
      OP_MAXU: begin
        new_w  = (old_w > opnd_w) ? old_w : opnd_w;
        new_dw = (mem_rdata_i > operand_q) ? mem_rdata_i : operand_q;
      end
      OP_MIN:  begin
        new_w  = ($signed(old_w) < $signed(opnd_w)) ? old_w : opnd_w;
        new_dw = ($signed(mem_rdata_i) < $signed(operand_q)) ? mem_rdata_i : operand_q;
      end
      OP_MINU: begin
        new_w  = (old_w < opnd_w) ? old_w : opnd_w;
        new_dw = (mem_rdata_i < operand_q) ? mem_rdata_i : operand_q;
      end
      default: begin new_w = opnd_w; new_dw = operand_q; end
    endcase
    new_wdata = is_word_q ? {new_w, new_w} : new_dw;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= 4'd0;
      is_word_q    <= 1'b0;
      addr_q       <= '0;
      operand_q    <= '0;
      amo_ack_o    <= 1'b0;
      amo_result_o <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_be_o     <= 8'h00;
    end else begin
      amo_ack_o <= 1'b0;
      case (state_q)
        IDLE: if (amo_req_valid_i) begin
          op_q       <= amo_op_i;
          is_word_q  <= req_word;
          addr_q     <= amo_addr_i;
          operand_q  <= amo_operand_i;
          mem_addr_o <= {amo_addr_i[ADDR_W-1:3], 3'b000};
          if (!req_legal) begin
            amo_result_o <= '0;
            amo_ack_o    <= 1'b1;
            state_q      <= RESP;
          end else if (amo_op_i == OP_SC) begin
            if (sc_match) begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_wdata_o <= req_word ? {amo_operand_i[31:0], amo_operand_i[31:0]} : amo_operand_i;
              mem_be_o    <= req_be;
              state_q     <= WR_REQ;
            end else begin
              amo_result_o <= DATA_W'(1);
              amo_ack_o    <= 1'b1;
              state_q      <= RESP;
            end
          end else begin
            mem_req_o <= 1'b1;
            mem_we_o  <= 1'b0;
            mem_be_o  <= 8'hFF;
            state_q   <= RD_REQ;
          end
        end
        RD_REQ: if (mem_gnt_i) begin
          mem_req_o <= 1'b0;
          state_q   <= RD_WAIT;
        end
        RD_WAIT: if (mem_rvalid_i) begin
          amo_result_o <= old_ext;
          if (op_q == OP_LR) begin
            amo_ack_o <= 1'b1;
            state_q   <= RESP;
          end else begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_wdata_o <= new_wdata;
            mem_be_o    <= q_be;
            state_q     <= WR_REQ;
          end
        end
        WR_REQ: if (mem_gnt_i) begin
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
          amo_ack_o <= 1'b1;
          if (op_q == OP_SC) amo_result_o <= '0;
          state_q   <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A snoop hitting the dword being reserved by this LR wins over the set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
    end else if (lr_done) begin
      rsv_valid_q <= !snoop_hit_cur;
      rsv_addr_q  <= addr_q[ADDR_W-1:3];
    end else if (sc_take || rsv_timeout || snoop_hit_rsv ||
                 (wr_done && (rsv_addr_q == addr_q[ADDR_W-1:3]))) begin
      rsv_valid_q <= 1'b0;
    end
  end

`ifdef AMO_RSV_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(RSV_TIMEOUT) + 1;
  logic [CNT_W-1:0] rsv_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            rsv_cnt_q <= '0;
    else if (lr_done)     rsv_cnt_q <= '0;
    else if (rsv_valid_q) rsv_cnt_q <= rsv_cnt_q + 1'b1;
  end

  assign rsv_timeout = rsv_valid_q && (rsv_cnt_q == CNT_W'(RSV_TIMEOUT - 1));
`else
  assign rsv_timeout = 1'b0;
`endif

endmodule
